// File: rtl/i2c_master_reg_rd.sv
// i2c_master_reg_rd: I2C master reading one or two bytes from a slave register.
// START, dev+W, reg, repeated START, dev+R, data, STOP on open-drain SCL/SDA.
module i2c_master_reg_rd #(
   parameter int CLK_DIV = 250
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [6:0]  dev_addr,
   input  logic [7:0]  reg_addr,
   input  logic        two_byte,
   output logic        busy,
   output logic        done,
   output logic        nack,
   output logic [15:0] rd_data,
   input  logic        scl_i,
   output logic        scl_oe,
   input  logic        sda_i,
   output logic        sda_oe
);
   localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

   typedef enum logic [3:0] {
      IDLE, START, WBYTE, WACK, RSTART,
      RBYTE, MACK, STOP, DONE
   } state_t;

   state_t        state;
   logic [QW-1:0] qcnt;
   logic [1:0]    quarter;
   logic [1:0]    wsel;
   logic [2:0]    bitcnt;
   logic [7:0]    shreg;
   logic [7:0]    reg_q;
   logic [6:0]    dev_q;
   logic          two_q;
   logic          second;
   logic          ack_bit;
   logic          sda_d;
   logic [15:0]   rx;
   logic          stretch;
   logic          scl_low;
   logic          scl_nxt;
   logic          sda_nxt;

   assign stretch = quarter[1] & ~scl_oe & ~scl_i;
   assign scl_low = ~quarter[1];

   always_comb begin
      scl_nxt = 1'b0;
      sda_nxt = 1'b0;
      unique case (state)
         START: sda_nxt = quarter[1];
         WBYTE: begin
            scl_nxt = scl_low;
            sda_nxt = ~shreg[7];
         end
         WACK, RBYTE: scl_nxt = scl_low;
         RSTART: begin
            scl_nxt = scl_low;
            sda_nxt = (quarter == 2'd3);
         end
         MACK: begin
            scl_nxt = scl_low;
            sda_nxt = two_q & ~second;
         end
         STOP: begin
            scl_nxt = scl_low;
            sda_nxt = (quarter != 2'd3);
         end
         default: ;
      endcase
   end

   // SDA trails SCL by one extra clk so it never moves on an SCL edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         qcnt    <= '0;
         quarter <= 2'd0;
         wsel    <= 2'd0;
         bitcnt  <= 3'd0;
         shreg   <= 8'h00;
         reg_q   <= 8'h00;
         dev_q   <= 7'h00;
         two_q   <= 1'b0;
         second  <= 1'b0;
         ack_bit <= 1'b0;
         sda_d   <= 1'b0;
         rx      <= 16'h0000;
         busy    <= 1'b0;
         done    <= 1'b0;
         nack    <= 1'b0;
         rd_data <= 16'h0000;
         scl_oe  <= 1'b0;
         sda_oe  <= 1'b0;
      end else begin
         done   <= 1'b0;
         scl_oe <= scl_nxt;
         sda_d  <= sda_nxt;
         sda_oe <= sda_d;
         case (state)
            IDLE: begin
               if (start) begin
                  dev_q   <= dev_addr;
                  reg_q   <= reg_addr;
                  two_q   <= two_byte;
                  busy    <= 1'b1;
                  nack    <= 1'b0;
                  rx      <= 16'h0000;
                  second  <= 1'b0;
                  qcnt    <= '0;
                  quarter <= 2'd0;
                  state   <= START;
               end
            end
            DONE: begin
               if (!nack)
                  rd_data <= two_q ? rx : {8'h00, rx[7:0]};
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               if (!stretch) begin
                  if (qcnt != QMAX) begin
                     qcnt <= qcnt + 1'b1;
                  end else begin
                     qcnt    <= '0;
                     quarter <= quarter + 2'd1;
                     if (quarter == 2'd2) begin
                        ack_bit <= sda_i;
                        if (state == RBYTE)
                           rx <= {rx[14:0], sda_i};
                     end
                     if (quarter == 2'd3) begin
                        case (state)
                           START: begin
                              shreg  <= {dev_q, 1'b0};
                              bitcnt <= 3'd7;
                              wsel   <= 2'd0;
                              state  <= WBYTE;
                           end
                           WBYTE: begin
                              if (bitcnt == 3'd0) begin
                                 state <= WACK;
                              end else begin
                                 bitcnt <= bitcnt - 3'd1;
                                 shreg  <= {shreg[6:0], 1'b0};
                              end
                           end
                           WACK: begin
                              if (ack_bit) begin
                                 nack  <= 1'b1;
                                 state <= STOP;
                              end else if (wsel == 2'd0) begin
                                 shreg  <= reg_q;
                                 bitcnt <= 3'd7;
                                 wsel   <= 2'd1;
                                 state  <= WBYTE;
                              end else if (wsel == 2'd1) begin
                                 state <= RSTART;
                              end else begin
                                 bitcnt <= 3'd7;
                                 state  <= RBYTE;
                              end
                           end
                           RSTART: begin
                              shreg  <= {dev_q, 1'b1};
                              bitcnt <= 3'd7;
                              wsel   <= 2'd2;
                              state  <= WBYTE;
                           end
                           RBYTE: begin
                              if (bitcnt == 3'd0)
                                 state <= MACK;
                              else
                                 bitcnt <= bitcnt - 3'd1;
                           end
                           MACK: begin
                              if (two_q && !second) begin
                                 second <= 1'b1;
                                 bitcnt <= 3'd7;
                                 state  <= RBYTE;
                              end else begin
                                 state <= STOP;
                              end
                           end
                           STOP: state <= DONE;
                           default: state <= IDLE;
                        endcase
                     end
                  end
               end
            end
         endcase
      end
   end
endmodule
